// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample ratio, FSM state encoding, data-width and parity constants.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  typedef enum logic [1:0] {
    DataBits5,
    DataBits6,
    DataBits7,
    DataBits8
  } uart_data_bits_e;

  localparam logic UART_PARITY_EVEN = 1'b0;
  localparam logic UART_PARITY_ODD  = 1'b1;

  // Everything needed to transmit one frame, captured at acceptance.
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] num_bit_data;
    logic       stop_bit;
    logic       parity_en;
    logic       parity_type;
  } uart_tx_frame_t;

  function automatic logic frame_parity(logic [7:0] data, logic [1:0] num_bit_data,
                                        logic parity_type);
    logic [7:0] mask;
    unique case (uart_data_bits_e'(num_bit_data))
      DataBits5: mask = 8'h1f;
      DataBits6: mask = 8'h3f;
      DataBits7: mask = 8'h7f;
      default:   mask = 8'hff;
    endcase
    return (^(data & mask)) ^ (parity_type == UART_PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side request/status bundle of the UART transmitter.
interface uart_tx_if;
  logic       i_tx_start;
  logic [7:0] i_data;
  logic [1:0] i_num_bit_data;
  logic       i_stop_bit;
  logic       i_parity_en;
  logic       i_parity_type;
  logic       o_ready;
  logic       o_busy;
  logic       o_tx_done;

  modport master (
    output i_tx_start, i_data, i_num_bit_data, i_stop_bit, i_parity_en, i_parity_type,
    input  o_ready, o_busy, o_tx_done
  );

  modport slave (
    input  i_tx_start, i_data, i_num_bit_data, i_stop_bit, i_parity_en, i_parity_type,
    output o_ready, o_busy, o_tx_done
  );
endinterface

// File: rtl/uart_tx_hold.sv
// One-entry hold register for a parked TX request; built only with UART_TX_HOLD_BUF_EN.
`ifdef UART_TX_HOLD_BUF_EN
module uart_tx_hold
  import uart_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           take,
  input  uart_tx_frame_t req,
  output uart_tx_frame_t held,
  output logic           valid,
  output logic           ready
);

  logic           valid_q;
  uart_tx_frame_t held_q;

  // load only happens while empty and take only while full, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      held_q  <= '0;
    end else begin
      if (take) valid_q <= 1'b0;
      if (load) begin
        valid_q <= 1'b1;
        held_q  <= req;
      end
    end
  end

  assign held  = held_q;
  assign valid = valid_q;
  assign ready = ~valid_q;

endmodule
`endif

// File: rtl/uart_tx.sv
// UART transmitter: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits on a 16x tick.
// UART_TX_HOLD_BUF_EN adds a one-entry hold buffer so frames can be sent back to back.
module uart_tx
  import uart_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    tx_tick,
  uart_tx_if.slave bus,
  output logic    o_tx_serial
);

  uart_state_e state_q;
  logic [3:0]  tick_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic        stop_cnt_q;
  logic [7:0]  shift_q;
  logic [1:0]  nbits_q;
  logic        stop2_q;
  logic        par_en_q;
  logic        par_bit_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;

  logic           ready, accept, launch, bit_end, last_bit, frame_end;
  uart_tx_frame_t req, launch_frame;

  assign req = '{data:         bus.i_data,
                 num_bit_data: bus.i_num_bit_data,
                 stop_bit:     bus.i_stop_bit,
                 parity_en:    bus.i_parity_en,
                 parity_type:  bus.i_parity_type};

  assign accept    = bus.i_tx_start && ready;
  assign bit_end   = tx_tick && (tick_cnt_q == 4'(UART_OVERSAMPLE - 1));
  assign last_bit  = bit_cnt_q == (3'd4 + 3'(nbits_q));
  assign frame_end = (state_q == StStop) && bit_end && (stop_cnt_q == stop2_q);

`ifdef UART_TX_HOLD_BUF_EN
  logic           hold_valid, direct;
  uart_tx_frame_t hold_frame;

  // A request goes straight to the line when nothing is queued ahead of it; otherwise it parks.
  assign direct       = accept && ((state_q == StIdle) || (frame_end && !hold_valid));
  assign launch       = direct || (frame_end && hold_valid);
  assign launch_frame = (frame_end && hold_valid) ? hold_frame : req;

  uart_tx_hold u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept && !direct),
    .take  (frame_end && hold_valid),
    .req   (req),
    .held  (hold_frame),
    .valid (hold_valid),
    .ready (ready)
  );
`else
  assign ready        = ~busy_q;
  assign launch       = accept;
  assign launch_frame = req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      nbits_q    <= '0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && tx_tick) tick_cnt_q <= tick_cnt_q + 4'd1;

      unique case (state_q)
        StIdle: begin
        end
        StStart: if (bit_end) begin
          state_q    <= StData;
          tick_cnt_q <= '0;
          tx_q       <= shift_q[0];
        end
        StData: if (bit_end) begin
          tick_cnt_q <= '0;
          if (last_bit) begin
            state_q <= par_en_q ? StParity : StStop;
            tx_q    <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            shift_q   <= shift_q >> 1;
            tx_q      <= shift_q[1];
          end
        end
        StParity: if (bit_end) begin
          state_q    <= StStop;
          tick_cnt_q <= '0;
          tx_q       <= 1'b1;
        end
        StStop: if (bit_end) begin
          tick_cnt_q <= '0;
          if (frame_end) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            stop_cnt_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Launch wins over the STOP->IDLE exit so a held frame follows with no idle gap.
      if (launch) begin
        state_q    <= StStart;
        tick_cnt_q <= '0;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        shift_q    <= launch_frame.data;
        nbits_q    <= launch_frame.num_bit_data;
        stop2_q    <= launch_frame.stop_bit;
        par_en_q   <= launch_frame.parity_en;
        par_bit_q  <= frame_parity(launch_frame.data, launch_frame.num_bit_data,
                                   launch_frame.parity_type);
        tx_q       <= 1'b0;
        busy_q     <= 1'b1;
      end
    end
  end

  assign o_tx_serial   = tx_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_tx_done = done_q;
  assign bus.o_ready   = ready;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx: expected frames are queued at issue, a line monitor
// reconstructs frames from mid-bit samples and compares them when o_tx_done pulses.
module tb_uart_tx;

  logic clk, rst_n, tx_tick, tx_serial;
  uart_tx_if bus ();

  uart_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_tick     (tx_tick),
    .bus         (bus),
    .o_tx_serial (tx_serial)
  );

  typedef struct {
    logic [11:0] bits;
    int          len;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     b2b    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x tick: one clk pulse every third cycle.
  initial begin
    int tcnt = 0;
    tx_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      tx_tick = (tcnt % 3 == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop bits high.
  function automatic frame_t model(logic [7:0] d, int nb, bit stop2, bit pen, bit podd);
    frame_t f;
    int     n = 5 + nb;
    bit     p = 0;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[1 + i] = d[i];
      p ^= d[i];
    end
    f.len = 1 + n;
    if (pen) begin
      f.bits[f.len] = p ^ podd;
      f.len++;
    end
    f.len += stop2 ? 2 : 1;
    return f;
  endfunction

  // Line monitor: counts ticks from the falling edge, samples each bit at its midpoint.
  initial begin
    int          ticks = 0;
    int          idx   = 0;
    bit          act   = 0;
    logic [11:0] cap   = '1;
    logic [11:0] m;
    frame_t      f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 0;
      end else begin
        if (bus.o_tx_done) begin
          chk("done_expected", 32'(act && exp_q.size() != 0), 32'd1);
          if (act && exp_q.size() != 0) begin
            f = exp_q.pop_front();
            m = '0;
            for (int i = 0; i < f.len; i++) m[i] = 1'b1;
            chk("frame_ticks", 32'(ticks), 32'(16 * f.len));
            chk("frame_bits", 32'(cap & m), 32'(f.bits & m));
          end
          act = 0;
        end
        if (!act && tx_serial == 1'b0) begin
          act   = 1;
          ticks = 0;
          idx   = 0;
          cap   = '1;
          if (bus.o_tx_done) b2b++;
        end
        if (act) begin
          if (idx < 12 && ticks == 16 * idx + 8) begin
            cap[idx] = tx_serial;
            idx++;
          end
          if (tx_tick) ticks++;
          if (ticks > 16 * 13) begin
            chk("frame_timeout", 32'(ticks), 32'(16 * 12));
            act = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] nb, input logic s2,
                      input logic pen, input logic pty, input bit expect_it);
    int waitc = 0;
    @(negedge clk);
    while (!bus.o_ready && waitc < 3000) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.o_ready) begin
      chk("ready_timeout", 32'(bus.o_ready), 32'd1);
      return;
    end
    bus.i_data         = d;
    bus.i_num_bit_data = nb;
    bus.i_stop_bit     = s2;
    bus.i_parity_en    = pen;
    bus.i_parity_type  = pty;
    bus.i_tx_start     = 1'b1;
    if (expect_it) exp_q.push_back(model(d, int'(nb), s2, pen, pty));
    @(negedge clk);
    bus.i_tx_start     = 1'b0;
    // Scramble inputs to show the accepted frame is unaffected.
    bus.i_data         = 8'($urandom);
    bus.i_num_bit_data = 2'($urandom);
    bus.i_stop_bit     = 1'($urandom);
    bus.i_parity_en    = 1'($urandom);
    bus.i_parity_type  = 1'($urandom);
    chk("busy_after_accept", 32'(bus.o_busy), 32'd1);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || bus.o_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.i_tx_start     = 1'b0;
    bus.i_data         = '0;
    bus.i_num_bit_data = '0;
    bus.i_stop_bit     = 1'b0;
    bus.i_parity_en    = 1'b0;
    bus.i_parity_type  = 1'b0;
    #22;
    chk("rst_line", 32'(tx_serial), 32'd1);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_done", 32'(bus.o_tx_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);  // 8N1
    send(8'hFF, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);  // 5E1
    send(8'h00, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);  // 7O2
    wait_quiet();

    for (int i = 0; i < 14; i++)
      send(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           1'($urandom), 1'b1);
    wait_quiet();

`ifdef UART_TX_HOLD_BUF_EN
    send(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_quiet();
    chk("back_to_back", 32'(b2b), 32'd1);
`else
    send(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (60) @(negedge clk);
    chk("ready_low_mid_frame", 32'(bus.o_ready), 32'd0);
    bus.i_data     = 8'h55;
    bus.i_tx_start = 1'b1;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    wait_quiet();
    chk("no_back_to_back", 32'(b2b), 32'd0);
`endif

    // Abandon a frame in DATA with an asynchronous reset.
    send(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (150) @(negedge clk);
    chk("in_frame_before_rst", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_line", 32'(tx_serial), 32'd1);
    chk("rst_mid_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_mid_done", 32'(bus.o_tx_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h96, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter paired with `uart_rx`. It frames one parallel byte per request into start, data (LSB first), optional parity and stop bits on `o_tx_serial`. Bit timing comes from a shared 16x-oversample tick, so frames match what `uart_rx` expects from the same configuration. It sits between the host-side register/FIFO logic and the TX pad.

## Interface
- No parameters; the oversample ratio is the fixed package constant `UART_OVERSAMPLE` = 16.
- `clk` input 1: system clock; single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_tick` input 1: one-`clk` pulse at 16x baud rate, from the shared baud generator.
- `i_num_bit_data` input 2: number of data bits = 5 + value (0→5 … 3→8).
- `i_stop_bit` input 1: 0 = one stop bit, 1 = two stop bits.
- `i_parity_en` input 1: 1 = insert a parity bit after the data bits.
- `i_parity_type` input 1: 0 = even parity, 1 = odd parity.
- `i_tx_start` input 1: request strobe. Accepted in any cycle where `o_ready`=1.
- `i_data` input 8: payload. Only bits `[4+i_num_bit_data:0]` are sent.
- `o_tx_serial` output 1: serial line; idles high.
- `o_ready` output 1: the block can accept a request this cycle.
- `o_busy` output 1: a frame is on the line.
- `o_tx_done` output 1: one-cycle pulse when a frame's last stop bit completes.

## Operation
- Reset values: `o_tx_serial`=1, `o_busy`=0, `o_ready`=1, `o_tx_done`=0. FSM is in IDLE; all counters are 0.
- **Acceptance:** when `i_tx_start && o_ready`, `i_data`, `i_num_bit_data`, `i_stop_bit`, `i_parity_en` and `i_parity_type` are latched. Input changes after acceptance do not affect that frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on acceptance.
  - START → DATA at the end of the bit.
  - DATA → PARITY (if parity enabled) or STOP after the last data bit.
  - PARITY → STOP.
  - STOP → IDLE, or → START if a held request is pending (macro builds only).
- **Bit timing:**
  - A 4-bit `tick_cnt` is cleared on entering each state and advances on `tx_tick`.
  - A bit ends on the `tx_tick` where `tick_cnt`=15.
  - STOP lasts 16 ticks, or 32 ticks when `i_stop_bit`=1 (a stop-bit counter selects which).
- **Line values:**
  - START drives 0.
  - DATA drives `shift_reg[0]` and shifts right at each bit end.
  - PARITY drives XOR of the sent data bits, inverted when odd parity is selected.
  - STOP and IDLE drive 1.
- **Bit count:** `bit_cnt` counts 0 … 4+`i_num_bit_data`. DATA exits at the bit end where `bit_cnt` equals that limit.
- **Request while not ready:** ignored silently. There is no error flag.
- **Reset mid-frame:** the line returns to 1 asynchronously and the frame is abandoned. No `o_tx_done` is issued.

## Timing
- Start bit first drives 0 in the cycle after acceptance (one register stage).
- Because the first bit is not aligned to `tx_tick`, the start bit may be up to one tick period short (≤1/16 bit). This is within `uart_rx` mid-bit sampling tolerance.
- Every later bit is exactly 16 tick periods.
- `o_tx_done` is registered and asserts in the cycle after the final stop tick.
- In that same cycle, `o_busy` falls, or stays high when a held frame launches.
- `o_busy` asserts in the cycle after acceptance.
- Frame length in ticks is 16 × (1 + data bits + parity_en + stop bits). Example: 8N1 = 160 ticks.

## Configuration
- Macro: `UART_TX_HOLD_BUF_EN`.
- **Undefined:**
  - No hold buffer.
  - `o_ready` = `~o_busy`.
  - At least one idle cycle separates consecutive frames.
- **Defined:**
  - A one-entry hold register (data plus config snapshot) is added.
  - `o_ready` = hold register empty.
  - A request accepted while busy is parked in the hold register.
  - At the final stop tick the FSM goes directly to START with the held frame, so the line has no idle gap.
  - `o_tx_done` pulses for the completed frame, and the hold register empties in the same cycle.
  - A request arriving in that same cycle is accepted into the now-free buffer one cycle later, because `o_ready` is registered.

## Structure
- Shared package `uart_pkg`:
  - `UART_OVERSAMPLE` = 16.
  - State encodings IDLE/START/DATA/PARITY/STOP, shared with `uart_rx`.
  - Data-width enumeration (5/6/7/8 bits).
  - Parity-type constants (EVEN=0, ODD=1).
- One sub-module, present only when `UART_TX_HOLD_BUF_EN` is defined: `uart_tx_hold`. It is the hold register plus its valid flag and the ready logic.
- The FSM, counters and shifter live in `uart_tx`.

## Test plan
- **8N1, `i_data`=8'hA5:** line shows 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks. `o_tx_done` pulses once, 160 ticks after start.
- **5 data bits, even parity, `i_data`=8'hFF:** sends 0,1,1,1,1,1,P=1,1. Upper 3 bits are never driven.
- **7 data bits, odd parity, 2 stop bits, `i_data`=8'h00:** parity bit=1 and stop held high for 32 ticks. Loopback into `uart_rx` gives `o_data`=8'h00 and `o_parity_err`=0.
- **`i_tx_start` pulsed mid-frame, macro off:** ignored. Line and `o_tx_done` count are unchanged.
- **Macro on, two requests (8'h3C, then 8'hC3 while busy):** frames are back-to-back with no high gap between the stop bit and the next start bit. `o_tx_done` pulses twice.
- **`rst_n` asserted during DATA:** `o_tx_serial`=1 immediately and no `o_tx_done`. The next request after release transmits a clean frame.
